// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: selects the next fetch PC from exception,
// ERET, branch redirect (buffered across stalls) or sequential increment.
module pc_gen #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
    parameter int unsigned      INC          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             pend_valid,
    output logic             misalign_f
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_target;
    logic             r_pend_valid;
    logic [WIDTH-1:0] w_pc_seq;

    assign w_pc_seq = r_pc + INC_W;

    // A live redirect during a stall overwrites the pending slot; an unstalled one
    // both redirects and discards whatever was pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_VECTOR;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (exc_req) begin
            r_pc         <= EXC_VECTOR;
            r_pend_valid <= 1'b0;
        end else if (eret_req) begin
            r_pc         <= epc_in;
            r_pend_valid <= 1'b0;
        end else if (br_valid && stall_f) begin
            r_pend_target <= br_target;
            r_pend_valid  <= 1'b1;
        end else if (br_valid) begin
            r_pc         <= br_target;
            r_pend_valid <= 1'b0;
        end else if (!stall_f) begin
            r_pc         <= r_pend_valid ? r_pend_target : w_pc_seq;
            r_pend_valid <= 1'b0;
        end
    end

    assign pc_f        = r_pc;
    assign pc_plus_inc = w_pc_seq;
    assign pend_valid  = r_pend_valid;
    assign misalign_f  = (r_pc[1:0] != 2'b00);

endmodule
